// File: rtl/matmul_pkg.sv
// Definitions shared by the matrix-multiply control, systolic and drain stages.
// Holds the default element width and matrix size plus the drain FSM encoding.
package matmul_pkg;

  localparam int W_DEFAULT = 32;
  localparam int N_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    REARM = 2'd2
  } drain_state_t;

endpackage

// File: rtl/drain_buffer.sv
// N*N x W result register file: one-cycle parallel load of the flattened
// result vector, combinational read port selected by element index.
module drain_buffer
  import matmul_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT,
  localparam int IW = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W*N*N-1:0] load_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [N*N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N*N; k++) mem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N*N; k++) mem[k] <= load_data[k*W +: W];
    end
  end

  // Compare-based mux so index codes past N*N-1 read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N*N; k++) begin
      if (rd_idx == IW'(k)) rd_data = mem[k];
    end
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots the matrix result on a rising done and streams it out row-major
// over valid/ready, then pulses a re-arm request. Option: RESULT_DRAIN_PARITY_EN adds o_par.
//
// state | meaning
// IDLE  | waiting for a fresh rise of i_done
// SEND  | presenting buf[idx]; advances on each accepted transfer
// REARM | one-cycle o_rearm pulse after the final transfer
module result_drain
  import matmul_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT,
  localparam int IW = $clog2(N*N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_done,
  input  logic [W*N*N-1:0] i_C,
  output logic [W-1:0]     o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IW-1:0]    o_idx,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_rearm,
`ifdef RESULT_DRAIN_PARITY_EN
  output logic             o_par,
`endif
  output logic             o_ovf
);

  localparam logic [IW-1:0] LAST = IW'(N*N-1);

  drain_state_t  state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          done_q;
  logic          ovf_q;
  logic          rise;
  logic          load;
  logic          sending;
  logic [W-1:0]  rd_data;

  assign rise    = i_done & ~done_q;
  assign sending = (state == SEND);

  drain_buffer #(
    .W (W),
    .N (N)
  ) u_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load),
    .load_data (i_C),
    .rd_idx    (idx),
    .rd_data   (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      done_q <= i_done;
      // A result landing while busy is dropped; only the flag records it.
      if (rise && (state != IDLE)) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (i_ready) begin
          if (idx == LAST) state_nxt = REARM;
          else             idx_nxt   = idx + IW'(1);
        end
      end
      REARM: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_valid = sending;
  assign o_data  = sending ? rd_data : '0;
  assign o_idx   = sending ? idx : '0;
  assign o_last  = sending && (idx == LAST);
  assign o_busy  = (state != IDLE);
  assign o_rearm = (state == REARM);
  assign o_ovf   = ovf_q;

`ifdef RESULT_DRAIN_PARITY_EN
  assign o_par = sending & (^rd_data);
`endif

endmodule

// File: tb/tb_result_drain.sv
// Randomized scoreboard bench for result_drain: a job-level model queues the
// expected elements at capture, a negedge monitor pops and compares transfers.
module tb_result_drain;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int NN = N*N;

  logic          clk = 1'b0;
  logic          rst, done, ready;
  logic [W*NN-1:0] c;
  logic [W-1:0]  data;
  logic          valid, last, busy, rearm, ovf;
  logic [3:0]    idx;
`ifdef RESULT_DRAIN_PARITY_EN
  logic          par;
`endif

  always #5 clk = ~clk;

  result_drain dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_done  (done),
    .i_C     (c),
    .o_data  (data),
    .o_valid (valid),
    .i_ready (ready),
    .o_idx   (idx),
    .o_last  (last),
    .o_busy  (busy),
    .o_rearm (rearm),
`ifdef RESULT_DRAIN_PARITY_EN
    .o_par   (par),
`endif
    .o_ovf   (ovf)
  );

  typedef struct {
    logic [W-1:0] d;
    int           k;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Job-level reference state: elements still owed, pending re-arm, sticky overflow.
  int   m_left  = 0;
  bit   m_rearm = 0;
  bit   m_ovf   = 0;
  bit   m_done_q = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < NN; k++) c[k*W +: W] = 32'h11 * (k + 1);
  endtask

  task automatic wait_idx(input int target);
    int n;
    n = 0;
    while (!(valid && idx == 4'(target)) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_idx: got idx %0d valid %0b expected idx %0d", idx, valid, target);
    end
  endtask

  // Reference model, evaluated on the inputs seen at each rising edge.
  initial begin
    bit   rise;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_left = 0; m_rearm = 0; m_ovf = 0; m_done_q = 0;
      end else begin
        rise = done && !m_done_q;
        m_done_q = done;
        if (m_left == 0 && !m_rearm) begin
          if (rise) begin
            for (int k = 0; k < NN; k++) begin
              e.d = c[k*W +: W];
              e.k = k;
              q.push_back(e);
            end
            m_left = NN;
          end
        end else begin
          if (rise) m_ovf = 1;
          if (m_rearm) m_rearm = 0;
          else if (ready) begin
            m_left--;
            if (m_left == 0) m_rearm = 1;
          end
        end
      end
    end
  end

  // Monitor: compares DUT against the model mid-cycle.
  initial begin
    bit           held;
    logic [W-1:0] hd;
    logic [3:0]   hi;
    exp_t         e;
    held = 0;
    forever begin
      @(negedge clk);
      chk("valid", 64'(valid), 64'(m_left != 0));
      chk("busy",  64'(busy),  64'((m_left != 0) || m_rearm));
      chk("rearm", 64'(rearm), 64'(m_rearm));
      chk("ovf",   64'(ovf),   64'(m_ovf));
      if (held) begin
        chk("hold_data", 64'(data), 64'(hd));
        chk("hold_idx",  64'(idx),  64'(hi));
        held = 0;
      end
`ifdef RESULT_DRAIN_PARITY_EN
      if (!valid) chk("par_idle", 64'(par), 64'(0));
`endif
      if (valid && !rst) begin
        if (ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer: got data %0h with no expected element", data);
          end else begin
            e = q.pop_front();
            chk("data", 64'(data), 64'(e.d));
            chk("idx",  64'(idx),  64'(e.k));
            chk("last", 64'(last), 64'(e.k == NN - 1));
`ifdef RESULT_DRAIN_PARITY_EN
            chk("par", 64'(par), 64'(^e.d));
`endif
          end
        end else begin
          held = 1;
          hd = data;
          hi = idx;
        end
      end
    end
  end

  initial begin
    rst = 1; done = 0; ready = 0; c = '0;
    repeat (3) step();
    chk("rst_data",  64'(data),  64'(0));
    chk("rst_idx",   64'(idx),   64'(0));
    chk("rst_last",  64'(last),  64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    rst = 0;
    step();

    // basic drain
    set_pattern();
    ready = 1; done = 1;
    step();
    done = 0;
    chk("basic_lat", 64'(valid), 64'(1));
    repeat (14) step();

    // back-pressure 1,0,0,1
    done = 1;
    step();
    done = 0;
    for (int i = 0; i < 60; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    ready = 1;
    repeat (4) step();

    // stale done held high
    done = 1;
    repeat (25) step();
    chk("stale_idle", 64'(valid), 64'(0));
    done = 0;
    step();
    done = 1;
    step();
    done = 0;
    repeat (12) step();

    // overflow at idx 4
    set_pattern();
    done = 1;
    step();
    done = 0;
    wait_idx(4);
    ready = 0;
    for (int k = 0; k < NN; k++) c[k*W +: W] = 32'hFF;
    done = 1;
    step();
    done = 0;
    ready = 1;
    repeat (12) step();
    chk("ovf_sticky", 64'(ovf), 64'(1));

    // reset mid-drain with done held through reset
    set_pattern();
    done = 1;
    step();
    wait_idx(3);
    rst = 1;
    step();
    chk("mid_rst_valid", 64'(valid), 64'(0));
    chk("mid_rst_ovf",   64'(ovf),   64'(0));
    chk("mid_rst_idx",   64'(idx),   64'(0));
    rst = 0;
    step();
    chk("rerise_valid", 64'(valid), 64'(1));
    done = 0;
    repeat (12) step();

    // parity-oriented elements
    for (int k = 0; k < NN; k++) c[k*W +: W] = $urandom;
    c[0 +: W] = 32'h7;
    c[W +: W] = 32'h3;
    done = 1;
    step();
    done = 0;
    repeat (12) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) done = ~done;
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < NN; k++) c[k*W +: W] = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; done = 0; ready = 1;
    repeat (15) step();
    chk("drained", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
